// File: rtl/load_store_unit.sv
// RV32I load/store stage: single-outstanding req/gnt/rvalid data-memory port, lane steering, load extension.
// Optional `define LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into a fault instead of an aligned access.
module load_store_unit #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [DataWidth-1:0] alu_out,
  input  logic [DataWidth-1:0] store_data,
  input  logic [4:0]           rd_addr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 wb_valid,
  output logic [DataWidth-1:0] wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_we,
  output logic                 misaligned_err
);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // mem_req holds address/data stable until the edge where mem_gnt is high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_wstrb_q, mem_wstrb_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [DataWidth-1:0] wb_data_q, wb_data_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic                 wb_we_q, wb_we_d;
  logic                 misaligned_err_q, misaligned_err_d;
  logic                 is_load_q, is_load_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [1:0]           lane_q, lane_d;

  logic [1:0]           in_lane;
  logic [3:0]           st_wstrb;
  logic [DataWidth-1:0] st_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                 in_misaligned;
`endif

  // Lane taken modulo the access size: halfwords use addr[1] only, words ignore both bits.
  function automatic logic [1:0] eff_lane(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   eff_lane = a;
      2'b01:   eff_lane = {a[1], 1'b0};
      default: eff_lane = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (f3)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extract = {24'd0, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b101:  extract = {16'd0, sh[15:0]};
      3'b010:  extract = rdata;
      default: extract = 32'd0;
    endcase
  endfunction

  always_comb begin
    state_d          = state_q;
    in_ready_d       = in_ready_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_wstrb_d      = mem_wstrb_q;
    wb_valid_d       = 1'b0;
    wb_data_d        = wb_data_q;
    wb_rd_d          = wb_rd_q;
    wb_we_d          = wb_we_q;
    misaligned_err_d = 1'b0;
    is_load_d        = is_load_q;
    funct3_d         = funct3_q;
    lane_d           = lane_q;

    in_lane = eff_lane(funct3, alu_out[1:0]);
    case (funct3)
      3'b000: begin
        st_wstrb = 4'b0001 << in_lane;
        st_wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        st_wstrb = 4'b0011 << in_lane;
        st_wdata = {2{store_data[15:0]}};
      end
      3'b010: begin
        st_wstrb = 4'b1111;
        st_wdata = store_data;
      end
      default: begin
        st_wstrb = 4'b0000;
        st_wdata = store_data;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    in_misaligned = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                    ((funct3 == 3'b010) && (alu_out[1:0] != 2'b00));
`endif

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          is_load_d  = is_load;
          funct3_d   = funct3;
          lane_d     = in_lane;
          wb_rd_d    = rd_addr;
          if (!(is_load || is_store)) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_data_d  = alu_out;
            wb_we_d    = (rd_addr != 5'd0);
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (in_misaligned) begin
            state_d          = DONE;
            wb_valid_d       = 1'b1;
            wb_data_d        = alu_out;
            wb_we_d          = 1'b0;
            misaligned_err_d = 1'b1;
          end
`endif
          else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = !is_load;
            mem_addr_d  = {alu_out[AddrWidth-1:2], 2'b00};
            mem_wstrb_d = is_load ? 4'b0000 : st_wstrb;
            mem_wdata_d = is_load ? '0 : st_wdata;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (is_load_q) begin
            state_d = RSP;
          end else begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            wb_we_d    = 1'b0;
          end
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_data_d  = extract(funct3_q, lane_q, mem_rdata);
          wb_we_d    = (wb_rd_q != 5'd0);
        end
      end
      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      in_ready_q       <= 1'b0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wstrb_q      <= 4'b0000;
      wb_valid_q       <= 1'b0;
      wb_data_q        <= '0;
      wb_rd_q          <= 5'd0;
      wb_we_q          <= 1'b0;
      misaligned_err_q <= 1'b0;
      is_load_q        <= 1'b0;
      funct3_q         <= 3'd0;
      lane_q           <= 2'd0;
    end else begin
      state_q          <= state_d;
      in_ready_q       <= in_ready_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wstrb_q      <= mem_wstrb_d;
      wb_valid_q       <= wb_valid_d;
      wb_data_q        <= wb_data_d;
      wb_rd_q          <= wb_rd_d;
      wb_we_q          <= wb_we_d;
      misaligned_err_q <= misaligned_err_d;
      is_load_q        <= is_load_d;
      funct3_q         <= funct3_d;
      lane_q           <= lane_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wstrb      = mem_wstrb_q;
  assign wb_valid       = wb_valid_q;
  assign wb_data        = wb_data_q;
  assign wb_rd          = wb_rd_q;
  assign wb_we          = wb_we_q;
  assign misaligned_err = misaligned_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: driver tasks, reactive memory responder, scoreboard queues and a
// reference model of the load/store rules; honours `define LSU_MISALIGN_TRAP_EN like the design.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_out, store_data;
  logic [4:0]  rd_addr;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_we, misaligned_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  load_store_unit #(.DataWidth(32), .AddrWidth(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .alu_out(alu_out),
    .store_data(store_data), .rd_addr(rd_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .misaligned_err(misaligned_err)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // {chk_data, err, we, rd[4:0], data[31:0], due_cycle[31:0]}
  logic [71:0] exp_q[$];
  // {we, wstrb[3:0], addr[31:0], wdata[31:0]}
  logic [68:0] exp_mem_q[$];
  logic [31:0] gnt_dly_q[$];
  logic [31:0] rv_dly_q[$];
  logic [31:0] rdata_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int lane_of(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (f3 == 3'd0 || f3 == 3'd4) return a;
    if (f3 == 3'd1 || f3 == 3'd5) return (a / 2) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * lane_of(f3, addr));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = v % 65536;
      3'd2: v = rdata;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    int s;
    s = 1 << lane_of(f3, addr);
    if (f3 == 3'd0) return 4'(s);
    if (f3 == 3'd1) return 4'(3 * s);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return 32'(sd[7:0]) * 32'h0101_0101;
    if (f3 == 3'd1) return 32'(sd[15:0]) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
    if (f3 == 3'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd, input int gd, input int rvd,
                       input logic [31:0] rdat, output int unsigned acc);
    int   n;
    bit   fault;
    int   lat;
    logic [31:0] d;
    bit   we, err, chkd;
    n = 0;
    is_load = ld; is_store = st; funct3 = f3; alu_out = addr; store_data = sd; rd_addr = rd;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("accept_timeout");
    acc = cyc;
    fault = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    fault = (ld || st) && model_misaligned(f3, addr);
`endif
    err = 1'b0; chkd = 1'b1;
    if (!(ld || st)) begin
      lat = 1; d = addr; we = (rd != 0);
    end else if (fault) begin
      lat = 1; d = addr; we = 1'b0; err = 1'b1;
    end else begin
      exp_mem_q.push_back({!ld, ld ? 4'h0 : model_strb(f3, addr), addr & 32'hFFFF_FFFC,
                           ld ? 32'h0 : model_wdata(f3, sd)});
      gnt_dly_q.push_back(32'(gd));
      rv_dly_q.push_back(32'(rvd));
      rdata_q.push_back(rdat);
      if (ld) begin
        lat = 3 + gd + rvd; d = model_load(f3, addr, rdat); we = (rd != 0);
      end else begin
        lat = 2 + gd; d = 32'h0; we = 1'b0; chkd = 1'b0;
      end
    end
    exp_q.push_back({chkd, err, we, rd, d, 32'(acc + lat)});
    @(negedge clk);
    in_valid = 1'b0;
    is_load = 1'($urandom); is_store = 1'($urandom); alu_out = $urandom;
  endtask

  // ---------------- memory responder (checks request side) ----------------
  initial begin
    int phase;
    int stall;
    int rvw;
    logic [68:0] cur;
    logic [31:0] rword;
    phase = 0; stall = 0; rvw = 0; cur = '0; rword = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (!rst_n) begin
        phase = 0;
        continue;
      end
      if (phase == 2) begin
        chk("mem_req_drop_after_gnt", mem_req, 1'b0);
        if (cur[68]) phase = 0;
        else if (rvw == 0) begin mem_rvalid = 1'b1; mem_rdata = rword; phase = 0; end
        else begin rvw--; phase = 3; end
      end else if (phase == 3) begin
        if (rvw == 0) begin mem_rvalid = 1'b1; mem_rdata = rword; phase = 0; end
        else rvw--;
      end
      if (phase == 0 && mem_req) begin
        if (exp_mem_q.size() == 0) fail_now("unexpected_mem_req");
        else begin
          cur = exp_mem_q.pop_front();
          stall = int'(gnt_dly_q.pop_front());
          rvw = int'(rv_dly_q.pop_front());
          rword = rdata_q.pop_front();
          phase = 1;
        end
      end
      if (phase == 1) begin
        if (!mem_req) begin
          fail_now("mem_req_dropped_before_gnt");
          phase = 0;
        end else begin
          chk("mem_we", mem_we, cur[68]);
          chk("mem_addr", mem_addr, cur[63:32]);
          if (cur[68]) begin
            chk("mem_wstrb", mem_wstrb, cur[67:64]);
            chk("mem_wdata", mem_wdata, cur[31:0]);
          end
          if (stall == 0) begin mem_gnt = 1'b1; phase = 2; end
          else stall--;
        end
      end
    end
  end

  // ---------------- writeback monitor ----------------
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_wb_valid");
        else begin
          e = exp_q.pop_front();
          chk("wb_latency", 32'(cyc), e[31:0]);
          chk("wb_rd", wb_rd, e[68:64]);
          chk("wb_we", wb_we, e[69]);
          chk("misaligned_err", misaligned_err, e[70]);
          if (e[71]) chk("wb_data", wb_data, e[63:32]);
        end
      end else if (rst_n && misaligned_err) begin
        fail_now("misaligned_err_without_wb_valid");
      end
    end
  end

  task automatic check_zero(input string name);
    chk(name, {in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_data,
               wb_rd, wb_we, misaligned_err}, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] ld_f3_tbl[6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

  initial begin
    int unsigned a1, a2, acc;
    int n;
    int op;
    rst_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    alu_out = '0; store_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0, acc);
    issue(0, 1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd0, 2, 0, 32'h0, acc);
    issue(1, 0, 3'd0, 32'h0000_0202, 32'h0, 5'd7, 0, 2, 32'h00F0_0000, acc);
    issue(1, 0, 3'd4, 32'h0000_0202, 32'h0, 5'd8, 0, 2, 32'h00F0_0000, acc);
    issue(1, 0, 3'd1, 32'h0000_0302, 32'h0, 5'd9, 0, 0, 32'h8001_0000, a1);
    issue(0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd10, 0, 0, 32'h0, a2);
    chk("back_to_back_accept", 32'(a2 - a1), 32'd4);
    issue(1, 0, 3'd2, 32'h0000_0401, 32'h0, 5'd11, 1, 1, 32'hCAFE_F00D, acc);
    issue(0, 1, 3'd1, 32'h0000_0503, 32'h1234_5678, 5'd3, 0, 0, 32'h0, acc);
    issue(1, 1, 3'd5, 32'h0000_0602, 32'h0, 5'd12, 0, 0, 32'hABCD_0123, acc);

    // Reset while waiting for rvalid, then a clean load
    issue(1, 0, 3'd2, 32'h0000_0700, 32'h0, 5'd13, 0, 10, 32'h1111_2222, acc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(); exp_mem_q.delete(); gnt_dly_q.delete(); rv_dly_q.delete(); rdata_q.delete();
    #1;
    check_zero("reset_in_rsp_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1, 0, 3'd2, 32'h0000_0800, 32'h0, 5'd14, 1, 1, 32'h3333_4444, acc);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0)
        issue(0, 0, 3'($urandom), $urandom, $urandom, 5'($urandom), 0, 0, 32'h0, acc);
      else if (op == 1)
        issue(1, ($urandom_range(0, 7) == 0), ld_f3_tbl[$urandom_range(0, 5)], $urandom, $urandom,
              5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, acc);
      else
        issue(0, 1, 3'($urandom_range(0, 2)), $urandom, $urandom, 5'($urandom),
              $urandom_range(0, 3), 0, 32'h0, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout_wb");
    repeat (3) @(negedge clk);
    chk("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute stage in the RV32I core.
- Consumes the ALU result as the effective address for loads and stores, and the store operand as write data.
- Drives a single-outstanding-request data-memory interface with a req/gnt/rvalid handshake.
- Hands a sign/zero-extended result to writeback. Non-memory ops pass the ALU result straight through.

Parameters:
- DataWidth, 32, datapath and memory word width; only 32 is supported.
- AddrWidth, 32, byte-address width.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute stage presents an instruction
- in_ready  output  1  unit can accept; transfer occurs when in_valid && in_ready
- is_load  input  1  op is a load
- is_store  input  1  op is a store (is_load && is_store is illegal; treat as load)
- funct3  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_out  input  DataWidth  effective address, or result for non-memory ops
- store_data  input  DataWidth  rs2 value for stores
- rd_addr  input  5  destination register
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  AddrWidth  word-aligned address (low 2 bits 0)
- mem_wdata  output  DataWidth  write data, lane-shifted
- mem_wstrb  output  4  byte enables
- mem_gnt  input  1  memory accepted the request this cycle
- mem_rvalid  input  1  read data valid (loads only)
- mem_rdata  input  DataWidth  read word
- wb_valid  output  1  one-cycle pulse, result valid
- wb_data  output  DataWidth  result
- wb_rd  output  5  destination register
- wb_we  output  1  register write enable; 0 for stores and faults
- misaligned_err  output  1  one-cycle pulse with wb_valid on a misaligned access

Behaviour:
- Reset: all outputs 0; FSM enters IDLE. Reset mid-transaction drops the transaction, with no wb_valid for it.
- FSM states:
  - IDLE: in_ready = 1. On accept, latch funct3, alu_out, store_data, rd_addr and op type.
    - Non-memory op → DONE.
    - Memory op → REQ.
  - REQ: mem_req = 1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_gnt.
    - On mem_gnt, a store → DONE and a load → RSP.
    - mem_req deasserts the cycle after gnt.
  - RSP: wait for mem_rvalid. Latch the extracted load value, then → DONE.
    - mem_rvalid arriving in the same cycle as gnt is not supported; memory guarantees rvalid ≥ 1 cycle after gnt.
  - DONE: wb_valid = 1 for exactly one cycle → IDLE. in_ready = 0 outside IDLE.
- Latency, accept to wb_valid:
  - Non-memory op: 1 cycle.
  - Store: 2 + grant wait cycles.
  - Load: 2 + grant wait + rvalid wait cycles.
- Byte lane = addr[1:0]. Store lane generation:
  - B: wstrb = 0001 << lane; wdata = {4{sd[7:0]}}.
  - H: wstrb = 0011 << lane; wdata = {2{sd[15:0]}}.
  - W: wstrb = 1111; wdata = sd.
- Load extraction:
  - B/BU: rdata >> (8·lane), bits [7:0], sign- or zero-extended.
  - H/HU: rdata >> (8·lane), bits [15:0], sign- or zero-extended.
  - W: whole word.
  - Unsupported funct3 on a load returns 0.
- wb_we: 1 for loads and non-memory ops with rd_addr != 0; 0 for stores.
- Misalignment: H with addr[0] = 1, or W with addr[1:0] != 00. Handling is governed by the optional feature.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- With the macro defined, a misaligned access skips REQ/RSP: no mem_req is issued and the FSM goes IDLE → DONE, giving wb_valid with misaligned_err = 1, wb_we = 0 and wb_data = faulting address.
- Without the macro, misaligned_err is tied 0. The access proceeds to the aligned word: mem_addr is the address with bits [1:0] cleared, and the lane shifts still use addr[1:0] modulo the access size (H uses addr[1] only; W ignores both bits).

Test Plan:
- Non-memory op: alu_out = 0x0000_1234, rd = 5 → wb_valid 1 cycle later, wb_data = 0x1234, wb_we = 1, mem_req never asserted.
- SB: addr = 0x103, sd = 0x0000_00AB, gnt after 2 stall cycles → mem_req held 3 cycles, mem_addr = 0x100, wstrb = 1000, wdata = 0xABAB_ABAB, wb_we = 0.
- LB and LBU: addr = 0x202, rdata = 0x00F0_0000 with rvalid 3 cycles after gnt → LB: wb_data = 0xFFFF_FFF0; LBU: wb_data = 0x0000_00F0.
- LH: addr = 0x302, rdata = 0x8001_0000 → wb_data = 0xFFFF_8001; back-to-back accept in the cycle after wb_valid succeeds.
- LW at 0x401:
  - With LSU_MISALIGN_TRAP_EN: no mem_req, misaligned_err = 1, wb_data = 0x401.
  - Without it: mem_addr = 0x400, full word returned.
- rst_n pulled low while in RSP → all outputs 0 immediately, no wb_valid; a new load after release completes normally.
